bso_counter: RTL
================

# bso_counter

Ball/strike/out count tracker for the scoreboard. Consumes the single-cycle event pulses generated by the per-button pulse generators and maintains the ball, strike and out counts shown on the display. It also emits one-cycle walk, strikeout and inning-change pulses for the downstream display and inning logic. Fully synchronous to one clock, with an asynchronous active-low reset.

## Interface
Parameters: none.

- iCLK  input  1  system clock; all state changes on rising edge
- iRSTn  input  1  reset; asynchronous, active-low; clears all state immediately
- iCLR  input  1  synchronous clear of all counts; highest priority
- iBALL  input  1  ball event, one-cycle pulse
- iSTRIKE  input  1  strike event, one-cycle pulse
- iOUT  input  1  out event (non-strikeout), one-cycle pulse
- iFOUL  input  1  foul event, one-cycle pulse; present only with FOUL_BALL_EN
- oBALL  output  2  ball count, 0..3
- oSTRIKE  output  2  strike count, 0..2
- oOUT  output  2  out count, 0..2
- oWALK  output  1  one-cycle pulse on the fourth ball
- oSTRIKEOUT  output  1  one-cycle pulse on the third strike
- oINNING  output  1  one-cycle pulse on the third out

## Operation
- State is the register triple {balls, strikes, outs}. All outputs are registered.
- Exactly one event is processed per cycle. Priority is iCLR > iOUT > iSTRIKE > iFOUL > iBALL. Lower-priority events asserted in the same cycle are discarded, not queued.
- iCLR:
  - balls, strikes and outs are set to 0.
  - No event pulse is emitted.
- iBALL:
  - balls < 3: balls + 1.
  - balls == 3: balls and strikes set to 0; oWALK = 1; outs unchanged.
- iSTRIKE:
  - strikes < 2: strikes + 1.
  - strikes == 2: balls and strikes set to 0; oSTRIKEOUT = 1; then the out-increment rule applies.
- iOUT: balls and strikes set to 0; then the out-increment rule applies.
- Out-increment rule:
  - outs < 2: outs + 1.
  - outs == 2: outs set to 0; oINNING = 1.
- A third-strike third out asserts oSTRIKEOUT and oINNING in the same cycle.
- Counts never exceed their stated maxima. Encodings 2'b11 of strikes and outs are unreachable.
- The block does not debounce or detect edges. An input held high for N cycles counts as N events; delivering one-cycle pulses is the upstream pulse generator's responsibility.

## Timing
- Reset values: oBALL = 0, oSTRIKE = 0, oOUT = 0, oWALK = 0, oSTRIKEOUT = 0, oINNING = 0.
- Latency: an event sampled at edge k is reflected in the counts after edge k. Any associated event pulse is high for exactly the cycle following edge k, aligned with the count update.
- With no event in a cycle, all pulse outputs return to 0 and the counts hold.
- Back-to-back events on consecutive cycles are each processed. A walk followed immediately by a ball gives balls = 1.
- Reset asserted mid-operation clears state and pulse outputs asynchronously. The first event is accepted on the first rising edge after iRSTn deasserts.

## Configuration
- FOUL_BALL_EN defined:
  - The iFOUL port exists.
  - strikes < 2: strikes + 1.
  - strikes == 2: no change. A foul never produces a strikeout.
  - Priority is below iSTRIKE and above iBALL.
- FOUL_BALL_EN undefined: the iFOUL port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset, then 3 iBALL pulses → oBALL = 3. A 4th pulse → oBALL = 0, oSTRIKE = 0, oWALK high for 1 cycle.
- From strikes = 2, outs = 2, balls = 1, one iSTRIKE → all counts 0; oSTRIKEOUT and oINNING high in the same single cycle.
- iBALL, iSTRIKE and iOUT asserted together from all-zero → oOUT = 1, oBALL = 0, oSTRIKE = 0, no pulses. The same pattern with iCLR also asserted → all 0.
- iBALL held high 5 cycles from 0 → counts 1, 2, 3, then walk (0), then 1; oWALK pulses once.
- FOUL_BALL_EN: 3 iFOUL pulses from 0 → oSTRIKE = 1, 2, 2; no oSTRIKEOUT. A following iSTRIKE → oSTRIKEOUT, oOUT = 1.
- iRSTn pulled low asynchronously mid-count (balls = 2, outs = 1) → all outputs 0 before the next clock edge; the first iBALL after release → oBALL = 1.

Source files
------------

// File: rtl/bso_counter_if.sv
// Event and count bundle between the scoreboard pulse generators and bso_counter.
// Latency: none (wires only).
// Backpressure: none; events are one-cycle pulses that are never stalled.
//
// Signals:
//   iCLR, iBALL, iSTRIKE, iOUT, iFOUL  event pulses into the counter
//                                      (iFOUL exists only when FOUL_BALL_EN is defined)
//   oBALL, oSTRIKE, oOUT               registered counts
//   oWALK, oSTRIKEOUT, oINNING         registered one-cycle result pulses
// Optional feature macro: FOUL_BALL_EN
interface bso_counter_if;
   logic       iCLR;
   logic       iBALL;
   logic       iSTRIKE;
   logic       iOUT;
`ifdef FOUL_BALL_EN
   logic       iFOUL;
`endif
   logic [1:0] oBALL;
   logic [1:0] oSTRIKE;
   logic [1:0] oOUT;
   logic       oWALK;
   logic       oSTRIKEOUT;
   logic       oINNING;

   // Event source side: drives the pulses, observes the counts.
   modport master (
`ifdef FOUL_BALL_EN
      output iFOUL,
`endif
      output iCLR, iBALL, iSTRIKE, iOUT,
      input  oBALL, oSTRIKE, oOUT, oWALK, oSTRIKEOUT, oINNING
   );

   // Counter side: consumes the pulses, drives the counts.
   modport slave (
`ifdef FOUL_BALL_EN
      input  iFOUL,
`endif
      input  iCLR, iBALL, iSTRIKE, iOUT,
      output oBALL, oSTRIKE, oOUT, oWALK, oSTRIKEOUT, oINNING
   );
endinterface

// File: rtl/bso_counter.sv
// Ball/strike/out tracker; emits walk, strikeout and inning-change pulses.
// Latency: event sampled at edge k shows in counts and pulses right after edge k.
// Backpressure: none; one event per cycle, lower-priority simultaneous events dropped.
//
// Ports:
//   iCLK   system clock, rising edge
//   iRSTn  asynchronous active-low reset, clears counts and pulses
//   bus    bso_counter_if.slave: event inputs and registered count/pulse outputs
// Optional feature macro: FOUL_BALL_EN (adds iFOUL: strike below 2, never a strikeout)
module bso_counter (
   input logic          iCLK,
   input logic          iRSTn,
   bso_counter_if.slave bus
);

   logic [1:0] balls_q,   balls_d;
   logic [1:0] strikes_q, strikes_d;
   logic [1:0] outs_q,    outs_d;
   logic       walk_q,    walk_d;
   logic       so_q,      so_d;
   logic       inning_q,  inning_d;
   logic       out_ev;    // an out is recorded this cycle (iOUT or third strike)

   always_comb begin
      balls_d   = balls_q;
      strikes_d = strikes_q;
      outs_d    = outs_q;
      walk_d    = 1'b0;
      so_d      = 1'b0;
      inning_d  = 1'b0;
      out_ev    = 1'b0;

      // Priority chain: only the highest-priority event in a cycle is used.
      if (bus.iCLR) begin
         balls_d   = 2'd0;
         strikes_d = 2'd0;
         outs_d    = 2'd0;
      end else if (bus.iOUT) begin
         balls_d   = 2'd0;
         strikes_d = 2'd0;
         out_ev    = 1'b1;
      end else if (bus.iSTRIKE) begin
         if (strikes_q < 2'd2) begin
            strikes_d = strikes_q + 2'd1;
         end else begin
            balls_d   = 2'd0;
            strikes_d = 2'd0;
            so_d      = 1'b1;
            out_ev    = 1'b1;
         end
`ifdef FOUL_BALL_EN
      end else if (bus.iFOUL) begin
         // A foul with two strikes leaves the count alone.
         if (strikes_q < 2'd2) begin
            strikes_d = strikes_q + 2'd1;
         end
`endif
      end else if (bus.iBALL) begin
         if (balls_q < 2'd3) begin
            balls_d = balls_q + 2'd1;
         end else begin
            balls_d   = 2'd0;
            strikes_d = 2'd0;
            walk_d    = 1'b1;
         end
      end

      // Shared out-increment rule for plain outs and strikeouts.
      if (out_ev) begin
         if (outs_q < 2'd2) begin
            outs_d = outs_q + 2'd1;
         end else begin
            outs_d   = 2'd0;
            inning_d = 1'b1;
         end
      end
   end

   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         balls_q   <= 2'd0;
         strikes_q <= 2'd0;
         outs_q    <= 2'd0;
         walk_q    <= 1'b0;
         so_q      <= 1'b0;
         inning_q  <= 1'b0;
      end else begin
         balls_q   <= balls_d;
         strikes_q <= strikes_d;
         outs_q    <= outs_d;
         walk_q    <= walk_d;
         so_q      <= so_d;
         inning_q  <= inning_d;
      end
   end

   assign bus.oBALL      = balls_q;
   assign bus.oSTRIKE    = strikes_q;
   assign bus.oOUT       = outs_q;
   assign bus.oWALK      = walk_q;
   assign bus.oSTRIKEOUT = so_q;
   assign bus.oINNING    = inning_q;

endmodule
